// File: rtl/taxi_prbs_lock_ctrl.sv
// Lock/error controller for a PRBS checker that follows a self-synchronizing descrambler.
// Sequences descrambler flush/reset, tracks hunt/lock, and keeps saturating error statistics.
module taxi_prbs_lock_ctrl #(
  parameter int DATA_W     = 64,
  parameter int LFSR_W     = 58,
  parameter int LOCK_CNT   = 4,
  parameter int WINDOW     = 16,
  parameter int ERR_THRESH = 4,
  parameter int CNT_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              stat_clear,
  output logic              desc_rst,
  output logic              locked,
  output logic              lock_loss,
  output logic [1:0]        state,
  output logic [CNT_W-1:0]  bit_err_count,
  output logic [CNT_W-1:0]  word_err_count
);

  localparam int FLUSH_WORDS = (LFSR_W + DATA_W - 1) / DATA_W;
  localparam int PC_W  = $clog2(DATA_W + 1);
  localparam int FL_W  = $clog2(FLUSH_WORDS + 1);
  localparam int CL_W  = $clog2(LOCK_CNT + 1);
  localparam int WN_W  = $clog2(WINDOW + 1);
  localparam int WE_W  = $clog2(ERR_THRESH + 1);
  localparam int SUM_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FLUSH  = 2'd1,
    S_HUNT   = 2'd2,
    S_LOCKED = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [FL_W-1:0]   r_flush_cnt;
  logic [CL_W-1:0]   r_clean_cnt;
  logic [WN_W-1:0]   r_win_cnt;
  logic [WE_W-1:0]   r_win_err;
  logic [PC_W-1:0]   w_popcnt;
  logic              w_err_word;
  logic [FL_W-1:0]   w_flush_inc;
  logic [CL_W-1:0]   w_clean_inc;
  logic [WN_W-1:0]   w_win_inc;
  logic [WE_W-1:0]   w_err_inc;
  logic              w_loss;
  logic              w_wrap;
  logic              w_count_en;
  logic              w_desc_rst_d;
  logic              w_locked_d;
  logic              w_lock_loss_d;
  logic              r_desc_rst;
  logic              r_locked;
  logic              r_lock_loss;
  logic [CNT_W-1:0]  r_bit_cnt;
  logic [CNT_W-1:0]  r_word_cnt;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [PC_W-1:0]  b);
    logic [SUM_W-1:0] s;
    s = SUM_W'(a) + SUM_W'(b);
    if (s > SUM_W'({CNT_W{1'b1}})) return '1;
    return s[CNT_W-1:0];
  endfunction

  always_comb begin
    w_popcnt = '0;
    for (int i = 0; i < DATA_W; i++) w_popcnt = w_popcnt + PC_W'(in_data[i]);
  end

  assign w_err_word  = |in_data;
  assign w_flush_inc = r_flush_cnt + FL_W'(1);
  assign w_clean_inc = r_clean_cnt + CL_W'(1);
  assign w_win_inc   = r_win_cnt + WN_W'(1);
  assign w_err_inc   = r_win_err + WE_W'(w_err_word);
  // Threshold is checked on the post-update error count and wins over window wrap.
  assign w_loss     = enable && (r_state == S_LOCKED) && in_valid && (w_err_inc == WE_W'(ERR_THRESH));
  assign w_wrap     = in_valid && (w_win_inc == WN_W'(WINDOW));
  assign w_count_en = enable && (r_state == S_LOCKED) && in_valid;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (!enable) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:   w_next = S_FLUSH;
        S_FLUSH:  if (in_valid && (w_flush_inc == FL_W'(FLUSH_WORDS))) w_next = S_HUNT;
        S_HUNT:   if (in_valid && !w_err_word && (w_clean_inc == CL_W'(LOCK_CNT))) w_next = S_LOCKED;
        S_LOCKED: if (w_loss) w_next = S_FLUSH;
        default:  w_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_desc_rst_d  = (w_next == S_IDLE) || w_loss;
    w_locked_d    = (w_next == S_LOCKED);
    w_lock_loss_d = w_loss;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_desc_rst  <= 1'b1;
      r_locked    <= 1'b0;
      r_lock_loss <= 1'b0;
    end else begin
      r_desc_rst  <= w_desc_rst_d;
      r_locked    <= w_locked_d;
      r_lock_loss <= w_lock_loss_d;
    end
  end

  // Every state change starts the per-state counters from zero.
  always_ff @(posedge clk) begin
    if (rst || (w_next != r_state)) begin
      r_flush_cnt <= '0;
      r_clean_cnt <= '0;
      r_win_cnt   <= '0;
      r_win_err   <= '0;
    end else if (in_valid) begin
      case (r_state)
        S_FLUSH: r_flush_cnt <= w_flush_inc;
        S_HUNT:  r_clean_cnt <= w_err_word ? '0 : w_clean_inc;
        S_LOCKED: begin
          if (w_wrap) begin
            r_win_cnt <= '0;
            r_win_err <= '0;
          end else begin
            r_win_cnt <= w_win_inc;
            r_win_err <= w_err_inc;
          end
        end
        default: ;
      endcase
    end
  end

  // stat_clear zeroes the base, so a same-cycle word's contribution still lands.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bit_cnt  <= '0;
      r_word_cnt <= '0;
    end else if (stat_clear || w_count_en) begin
      r_bit_cnt  <= sat_add(stat_clear ? '0 : r_bit_cnt,
                            w_count_en ? w_popcnt : '0);
      r_word_cnt <= sat_add(stat_clear ? '0 : r_word_cnt,
                            PC_W'(w_count_en && w_err_word));
    end
  end

  assign desc_rst       = r_desc_rst;
  assign locked         = r_locked;
  assign lock_loss      = r_lock_loss;
  assign state          = r_state;
  assign bit_err_count  = r_bit_cnt;
  assign word_err_count = r_word_cnt;

endmodule

// File: tb/tb_taxi_prbs_lock_ctrl.sv
// Directed bench for taxi_prbs_lock_ctrl: default instance plus a CNT_W=4 instance for saturation.
module tb_taxi_prbs_lock_ctrl;

  logic        clk;
  logic        rst;
  logic        enable;
  logic [63:0] in_data;
  logic        in_valid;
  logic        stat_clear;

  logic        desc_rst;
  logic        locked;
  logic        lock_loss;
  logic [1:0]  state;
  logic [31:0] bit_err_count;
  logic [31:0] word_err_count;

  logic        s_desc_rst;
  logic        s_locked;
  logic        s_lock_loss;
  logic [1:0]  s_state;
  logic [3:0]  s_bit_err_count;
  logic [3:0]  s_word_err_count;

  int n_tests;
  int n_fail;

  taxi_prbs_lock_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .enable         (enable),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .stat_clear     (stat_clear),
    .desc_rst       (desc_rst),
    .locked         (locked),
    .lock_loss      (lock_loss),
    .state          (state),
    .bit_err_count  (bit_err_count),
    .word_err_count (word_err_count)
  );

  taxi_prbs_lock_ctrl #(.CNT_W(4)) dut_small (
    .clk            (clk),
    .rst            (rst),
    .enable         (enable),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .stat_clear     (stat_clear),
    .desc_rst       (s_desc_rst),
    .locked         (s_locked),
    .lock_loss      (s_lock_loss),
    .state          (s_state),
    .bit_err_count  (s_bit_err_count),
    .word_err_count (s_word_err_count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Apply one cycle of inputs, then sample outputs 1ns after the edge.
  task automatic step(input logic v, input logic [63:0] d, input logic clr);
    in_valid   = v;
    in_data    = d;
    stat_clear = clr;
    @(posedge clk);
    #1;
    in_valid   = 1'b0;
    in_data    = '0;
    stat_clear = 1'b0;
  endtask

  task automatic clean_words(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 64'h0, 1'b0);
  endtask

  task automatic check_state(input string tag, input logic [1:0] st, input logic lk);
    check({tag, "_state"}, 64'(state), 64'(st));
    check({tag, "_locked"}, 64'(locked), 64'(lk));
  endtask

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    rst        = 1'b1;
    enable     = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    stat_clear = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // reset values
    check_state("rst", 2'd0, 1'b0);
    check("rst_desc_rst", 64'(desc_rst), 64'd1);
    check("rst_lock_loss", 64'(lock_loss), 64'd0);
    check("rst_bit_cnt", 64'(bit_err_count), 64'd0);
    check("rst_word_cnt", 64'(word_err_count), 64'd0);

    // basic acquisition: 1 flush word + 4 clean words
    rst    = 1'b0;
    enable = 1'b1;
    step(1'b0, 64'h0, 1'b0);
    check_state("acq_flush", 2'd1, 1'b0);
    check("acq_flush_desc_rst", 64'(desc_rst), 64'd0);
    step(1'b1, 64'h0, 1'b0);
    check_state("acq_hunt", 2'd2, 1'b0);
    clean_words(3);
    check_state("acq_hunt4", 2'd2, 1'b0);
    step(1'b1, 64'h0, 1'b0);
    check_state("acq_locked", 2'd3, 1'b1);
    check("acq_bit_cnt", 64'(bit_err_count), 64'd0);

    // enable low from LOCKED: IDLE, no loss pulse
    enable = 1'b0;
    step(1'b0, 64'h0, 1'b0);
    check_state("dis", 2'd0, 1'b0);
    check("dis_desc_rst", 64'(desc_rst), 64'd1);
    check("dis_lock_loss", 64'(lock_loss), 64'd0);

    // hunt restart: clean, clean, err, clean x4
    enable = 1'b1;
    step(1'b0, 64'h0, 1'b0);
    step(1'b1, 64'h0, 1'b0);
    check_state("hunt_entry", 2'd2, 1'b0);
    clean_words(2);
    step(1'b1, 64'h1, 1'b0);
    clean_words(3);
    check_state("hunt_reset", 2'd2, 1'b0);
    step(1'b1, 64'h0, 1'b0);
    check_state("hunt_lock", 2'd3, 1'b1);
    check("hunt_word_cnt", 64'(word_err_count), 64'd0);

    // three errored words inside a window, 4 bits total
    step(1'b1, 64'h3, 1'b0);
    step(1'b1, 64'h0, 1'b0);
    step(1'b1, 64'h1, 1'b0);
    step(1'b1, 64'h0, 1'b0);
    step(1'b1, 64'h8000_0000_0000_0000, 1'b0);
    check_state("win_err3", 2'd3, 1'b1);
    check("win_err3_bit", 64'(bit_err_count), 64'd4);
    check("win_err3_word", 64'(word_err_count), 64'd3);
    clean_words(11);

    // 3 errors at end of a window, 3 at start of the next: wrap clears
    clean_words(13);
    repeat (3) step(1'b1, 64'h1, 1'b0);
    repeat (3) step(1'b1, 64'h1, 1'b0);
    check_state("wrap", 2'd3, 1'b1);
    check("wrap_lock_loss", 64'(lock_loss), 64'd0);
    check("wrap_word", 64'(word_err_count), 64'd9);
    check("wrap_bit", 64'(bit_err_count), 64'd10);
    clean_words(13);

    // saturation on the CNT_W=4 instance, then stat_clear with a word
    step(1'b1, 64'h3FFF, 1'b1);
    check("sat_pre_bit", 64'(s_bit_err_count), 64'd14);
    step(1'b1, 64'hFF, 1'b0);
    check("sat_bit", 64'(s_bit_err_count), 64'd15);
    check("sat_word", 64'(s_word_err_count), 64'd2);
    check("nosat_bit", 64'(bit_err_count), 64'd22);
    step(1'b1, 64'h3, 1'b1);
    check("clr_bit", 64'(bit_err_count), 64'd2);
    check("clr_word", 64'(word_err_count), 64'd1);
    check("clr_small_bit", 64'(s_bit_err_count), 64'd2);
    check_state("clr", 2'd3, 1'b1);
    clean_words(13);

    // loss of lock: 4 errored words in one window
    step(1'b1, 64'h0, 1'b1);
    check("loss_clr_bit", 64'(bit_err_count), 64'd0);
    step(1'b1, 64'h1, 1'b0);
    step(1'b1, 64'h0, 1'b0);
    step(1'b1, 64'h1, 1'b0);
    step(1'b1, 64'h1, 1'b0);
    check_state("loss_pre", 2'd3, 1'b1);
    check("loss_pre_pulse", 64'(lock_loss), 64'd0);
    step(1'b1, 64'h1, 1'b0);
    check_state("loss", 2'd1, 1'b0);
    check("loss_pulse", 64'(lock_loss), 64'd1);
    check("loss_desc_rst", 64'(desc_rst), 64'd1);
    check("loss_word", 64'(word_err_count), 64'd4);
    check("loss_bit", 64'(bit_err_count), 64'd4);
    step(1'b0, 64'h0, 1'b0);
    check("loss_pulse_end", 64'(lock_loss), 64'd0);
    check("loss_desc_rst_end", 64'(desc_rst), 64'd0);
    check_state("loss_flush", 2'd1, 1'b0);
    step(1'b1, 64'h0, 1'b0);
    check_state("loss_hunt", 2'd2, 1'b0);
    step(1'b1, 64'h1, 1'b0);
    check("hunt_no_count", 64'(word_err_count), 64'd4);

    // mid-operation reset
    rst = 1'b1;
    step(1'b1, 64'h0, 1'b0);
    check_state("midrst", 2'd0, 1'b0);
    check("midrst_desc_rst", 64'(desc_rst), 64'd1);
    check("midrst_word", 64'(word_err_count), 64'd0);
    check("midrst_small_state", 64'(s_state), 64'd0);
    check("midrst_small_flags", 64'({s_desc_rst, s_locked, s_lock_loss}), 64'b100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
